// File: rtl/tcb_pkg.sv
// Shared types and default widths for the inference controller.
package tcb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int IMG_W_DEF  = 1024;
  localparam int PRED_W_DEF = 32;
  localparam int LBL_W_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/tcb_sat_cnt.sv
// Saturating up-counter with increment enable and synchronous clear.
module tcb_sat_cnt
  import tcb_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tcb_infer_ctrl.sv
// One-frame-in-flight controller between an image source, a network core and a result sink.
// Optional watchdog on the network response is enabled by defining TCB_WATCHDOG_EN.
module tcb_infer_ctrl
  import tcb_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int PRED_W      = PRED_W_DEF,
  parameter int LBL_W       = LBL_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IMG_W-1:0]  img_in,
  input  logic [LBL_W-1:0]  lbl_in,
  input  logic              img_valid,
  output logic              img_ready,
  output logic [IMG_W-1:0]  img_source,
  output logic              valid_top,
  input  logic              ready_top,
  input  logic [PRED_W-1:0] number,
  output logic [PRED_W-1:0] pred,
  output logic              pred_timeout,
  output logic              pred_valid,
  input  logic              pred_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic              busy
);

  state_e            state_q;
  logic [IMG_W-1:0]  img_q;
  logic [LBL_W-1:0]  lbl_q;
  logic [PRED_W-1:0] pred_q;
  logic              valid_top_q;
  logic              pred_valid_q;
  logic              busy_q;
  logic              tmo_q;
  logic              done_d;
  logic              match_d;

`ifdef TCB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;
  logic            expire_d;

  // Fires in the TIMEOUT_CYC-th WAIT cycle, so WAIT lasts exactly TIMEOUT_CYC cycles.
  assign expire_d = (wdog_q == WD_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      img_q        <= '0;
      lbl_q        <= '0;
      pred_q       <= '0;
      valid_top_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
`ifdef TCB_WATCHDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (img_valid) begin
            img_q       <= img_in;
            lbl_q       <= lbl_in;
            valid_top_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          valid_top_q <= 1'b0;
          state_q     <= WAIT;
`ifdef TCB_WATCHDOG_EN
          wdog_q      <= '0;
`endif
        end
        WAIT: begin
`ifdef TCB_WATCHDOG_EN
          wdog_q <= wdog_q + WD_W'(1);
`endif
          // A real result wins over a simultaneous watchdog expiry.
          if (ready_top) begin
            pred_q       <= number;
            tmo_q        <= 1'b0;
            pred_valid_q <= 1'b1;
            state_q      <= HOLD;
          end
`ifdef TCB_WATCHDOG_EN
          else if (expire_d) begin
            pred_q       <= '1;
            tmo_q        <= 1'b1;
            pred_valid_q <= 1'b1;
            state_q      <= HOLD;
          end
`endif
        end
        HOLD: begin
          if (pred_ready) begin
            pred_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_d  = (state_q == HOLD) && pred_ready;
  assign match_d = !pred_timeout && (pred_q == PRED_W'(lbl_q));

  tcb_sat_cnt #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (done_d),
    .cnt_o (frame_cnt)
  );

  tcb_sat_cnt #(.W(CNT_W)) u_correct_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (done_d && match_d),
    .cnt_o (correct_cnt)
  );

  assign img_ready  = (state_q == IDLE) && !rst;
  assign img_source = img_q;
  assign valid_top  = valid_top_q;
  assign pred       = pred_q;
  assign pred_valid = pred_valid_q;
  assign busy       = busy_q;
`ifdef TCB_WATCHDOG_EN
  assign pred_timeout = tmo_q;
`else
  assign pred_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tcb_infer_ctrl.sv
// Directed bench for tcb_infer_ctrl: a vector table for the first frames, then hand-written multi-cycle sequences.
module tb_tcb_infer_ctrl;

  localparam int IMG_W = 16;
  localparam int PRED_W = 32;
  localparam int LBL_W = 4;
  localparam int CNT_W = 3;
  localparam int TMO = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [IMG_W-1:0]  img_in;
  logic [LBL_W-1:0]  lbl_in;
  logic              img_valid;
  logic              img_ready;
  logic [IMG_W-1:0]  img_source;
  logic              valid_top;
  logic              ready_top;
  logic [PRED_W-1:0] number;
  logic [PRED_W-1:0] pred;
  logic              pred_timeout;
  logic              pred_valid;
  logic              pred_ready;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  correct_cnt;
  logic              busy;

  always #5 clk = ~clk;

  tcb_infer_ctrl #(
    .IMG_W(IMG_W), .PRED_W(PRED_W), .LBL_W(LBL_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .img_in(img_in), .lbl_in(lbl_in), .img_valid(img_valid),
    .img_ready(img_ready), .img_source(img_source), .valid_top(valid_top),
    .ready_top(ready_top), .number(number), .pred(pred), .pred_timeout(pred_timeout),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .frame_cnt(frame_cnt),
    .correct_cnt(correct_cnt), .busy(busy)
  );

  typedef struct {
    logic              rst;
    logic              iv;
    logic [IMG_W-1:0]  img;
    logic [LBL_W-1:0]  lbl;
    logic              rt;
    logic [PRED_W-1:0] num;
    logic              pr;
    logic              e_ir;
    logic              e_vt;
    logic              e_pv;
    logic              e_busy;
    logic [PRED_W-1:0] e_pred;
    logic [IMG_W-1:0]  e_src;
    logic [CNT_W-1:0]  e_fc;
    logic [CNT_W-1:0]  e_cc;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;
  int exp_cc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic int sat(input int x);
    return (x < (1 << CNT_W) - 1) ? x + 1 : x;
  endfunction

  // From IDLE: accept one frame, then step into the first WAIT cycle.
  task automatic launch(input logic [IMG_W-1:0] im, input logic [LBL_W-1:0] lb);
    img_valid = 1'b1; img_in = im; lbl_in = lb; ready_top = 1'b0; pred_ready = 1'b0;
    tick;
    chk("launch_valid_top", 64'(valid_top), 64'd1);
    chk("launch_img_source", 64'(img_source), 64'(im));
    img_valid = 1'b0;
    tick;
    chk("wait_valid_top", 64'(valid_top), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  // Free-running frames with everything ready; counts launches and checks img_source stability.
  task automatic stream(input int ncyc, output int pulses);
    logic             acc;
    logic             prev_busy;
    logic [IMG_W-1:0] prev_src;
    pulses = 0;
    img_valid = 1'b1; lbl_in = 4'd5; ready_top = 1'b1; number = 32'd5; pred_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      acc = img_ready && img_valid;
      prev_busy = busy;
      prev_src = img_source;
      if (pred_valid && pred_ready) begin
        exp_fc = sat(exp_fc);
        exp_cc = sat(exp_cc);
      end
      tick;
      if (valid_top) pulses++;
      if (img_source != prev_src) chk("src_changes_from_idle", 64'(prev_busy), 64'd0);
      chk("stream_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
      if (acc) img_in = img_in + IMG_W'(1);
    end
    img_valid = 1'b0; ready_top = 1'b0; pred_ready = 1'b0;
  endtask

  int pulses;

  initial begin
    rst = 1'b1; img_in = '0; lbl_in = '0; img_valid = 1'b0;
    ready_top = 1'b0; number = '0; pred_ready = 1'b0;

    //        rst iv img        lbl   rt    num    pr  | ir vt pv bsy pred   src        fc    cc
    vt[0]  = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'h0000, 3'd0, 3'd0};
    vt[1]  = '{1'b0, 1'b1, 16'hA5C3, 4'd3, 1'b1, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 16'hA5C3, 3'd0, 3'd0};
    vt[2]  = '{1'b0, 1'b0, 16'hA5C3, 4'd3, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 16'hA5C3, 3'd0, 3'd0};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 16'hA5C3, 3'd0, 3'd0};
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = vt[3];
    vt[7]  = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 16'hA5C3, 3'd0, 3'd0};
    vt[8]  = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 16'hA5C3, 3'd0, 3'd0};
    vt[9]  = '{1'b0, 1'b1, 16'h3C96, 4'd2, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 16'hA5C3, 3'd1, 3'd1};
    vt[10] = '{1'b0, 1'b1, 16'h3C96, 4'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3, 16'h3C96, 3'd1, 3'd1};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 16'h3C96, 3'd1, 3'd1};
    vt[12] = '{1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd7, 16'h3C96, 3'd1, 3'd1};

    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; img_valid = vt[i].iv; img_in = vt[i].img; lbl_in = vt[i].lbl;
      ready_top = vt[i].rt; number = vt[i].num; pred_ready = vt[i].pr;
      tick;
      chk($sformatf("v%0d_img_ready", i), 64'(img_ready), 64'(vt[i].e_ir));
      chk($sformatf("v%0d_valid_top", i), 64'(valid_top), 64'(vt[i].e_vt));
      chk($sformatf("v%0d_pred_valid", i), 64'(pred_valid), 64'(vt[i].e_pv));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
      chk($sformatf("v%0d_pred", i), 64'(pred), 64'(vt[i].e_pred));
      chk($sformatf("v%0d_pred_timeout", i), 64'(pred_timeout), 64'd0);
      chk($sformatf("v%0d_img_source", i), 64'(img_source), 64'(vt[i].e_src));
      chk($sformatf("v%0d_frame_cnt", i), 64'(frame_cnt), 64'(vt[i].e_fc));
      chk($sformatf("v%0d_correct_cnt", i), 64'(correct_cnt), 64'(vt[i].e_cc));
    end
    exp_fc = 1; exp_cc = 1;

    // Mismatched result held under backpressure; new images must be refused.
    ready_top = 1'b0; pred_ready = 1'b0; img_valid = 1'b1; img_in = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_pred", 64'(pred), 64'd7);
      chk("bp_pred_valid", 64'(pred_valid), 64'd1);
      chk("bp_img_ready", 64'(img_ready), 64'd0);
      chk("bp_img_source", 64'(img_source), 64'h3C96);
    end
    img_valid = 1'b0; pred_ready = 1'b1;
    tick;
    exp_fc = sat(exp_fc);
    chk("bp_done_pred_valid", 64'(pred_valid), 64'd0);
    chk("bp_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    chk("bp_correct_cnt", 64'(correct_cnt), 64'(exp_cc));
    pred_ready = 1'b0;

    // Three back-to-back frames: 4 cycles each.
    img_in = 16'h1000;
    stream(12, pulses);
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("b2b_last_src", 64'(img_source), 64'h1002);
    chk("b2b_idle", 64'(busy), 64'd0);
    chk("b2b_frame_cnt", 64'(frame_cnt), 64'd5);
    chk("b2b_correct_cnt", 64'(correct_cnt), 64'd4);

`ifdef TCB_WATCHDOG_EN
    launch(16'h7777, 4'd6);
    for (int i = 0; i < TMO - 1; i++) begin
      tick;
      chk("wd_still_waiting", 64'(pred_valid), 64'd0);
    end
    tick;
    chk("wd_pred_valid", 64'(pred_valid), 64'd1);
    chk("wd_pred", 64'(pred), 64'hFFFF_FFFF);
    chk("wd_pred_timeout", 64'(pred_timeout), 64'd1);
    pred_ready = 1'b1;
    tick;
    exp_fc = sat(exp_fc);
    chk("wd_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    chk("wd_correct_cnt", 64'(correct_cnt), 64'(exp_cc));
    pred_ready = 1'b0;

    launch(16'h8888, 4'd4);
    for (int i = 0; i < TMO - 1; i++) tick;
    ready_top = 1'b1; number = 32'd4;
    tick;
    chk("tie_pred_valid", 64'(pred_valid), 64'd1);
    chk("tie_pred", 64'(pred), 64'd4);
    chk("tie_pred_timeout", 64'(pred_timeout), 64'd0);
    ready_top = 1'b0; pred_ready = 1'b1;
    tick;
    exp_fc = sat(exp_fc); exp_cc = sat(exp_cc);
    chk("tie_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    chk("tie_correct_cnt", 64'(correct_cnt), 64'(exp_cc));
    pred_ready = 1'b0;
`else
    launch(16'h7777, 4'd6);
    for (int i = 0; i < 40; i++) begin
      tick;
      chk("nowd_still_waiting", 64'(pred_valid), 64'd0);
      chk("nowd_busy", 64'(busy), 64'd1);
    end
    ready_top = 1'b1; number = 32'd6;
    tick;
    chk("nowd_pred", 64'(pred), 64'd6);
    chk("nowd_pred_timeout", 64'(pred_timeout), 64'd0);
    ready_top = 1'b0; pred_ready = 1'b1;
    tick;
    exp_fc = sat(exp_fc); exp_cc = sat(exp_cc);
    chk("nowd_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    chk("nowd_correct_cnt", 64'(correct_cnt), 64'(exp_cc));
    pred_ready = 1'b0;
`endif

    // Reset mid-WAIT abandons the frame; a late ready_top must not resurrect it.
    launch(16'hD00D, 4'd1);
    tick;
    rst = 1'b1;
    tick;
    chk("rst_img_ready", 64'(img_ready), 64'd0);
    chk("rst_valid_top", 64'(valid_top), 64'd0);
    chk("rst_pred_valid", 64'(pred_valid), 64'd0);
    chk("rst_pred", 64'(pred), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_img_source", 64'(img_source), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_correct_cnt", 64'(correct_cnt), 64'd0);
    rst = 1'b0; ready_top = 1'b1; number = 32'd1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("late_rt_pred_valid", 64'(pred_valid), 64'd0);
      chk("late_rt_img_ready", 64'(img_ready), 64'd1);
      chk("late_rt_frame_cnt", 64'(frame_cnt), 64'd0);
    end
    ready_top = 1'b0;
    exp_fc = 0; exp_cc = 0;

    // Nine matching frames push both 3-bit counters into saturation.
    img_in = 16'h2000;
    stream(36, pulses);
    chk("sat_pulses", 64'(pulses), 64'd9);
    chk("sat_frame_cnt", 64'(frame_cnt), 64'd7);
    chk("sat_correct_cnt", 64'(correct_cnt), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tcb_infer_ctrl.md
TCB_INFER_CTRL -- requirements
Module: tcb_infer_ctrl

Interface
REQ-001 Parameters SHALL be: IMG_W, default 1024, image vector width; PRED_W, default 32, prediction width; LBL_W, default 4, label width; CNT_W, default 16, statistics counter width; TIMEOUT_CYC, default 4095, watchdog limit in cycles.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- img_in  in  IMG_W  upstream image.
- lbl_in  in  LBL_W  reference label for img_in.
- img_valid  in  1  upstream has an image.
- img_ready  out  1  controller accepts the image.
- img_source  out  IMG_W  image to the network top.
- valid_top  out  1  start pulse to the network.
- ready_top  in  1  network result available.
- number  in  PRED_W  network prediction.
- pred  out  PRED_W  delivered prediction.
- pred_timeout  out  1  pred is a watchdog result.
- pred_valid  out  1  result offered downstream.
- pred_ready  in  1  downstream accepts the result.
- frame_cnt  out  CNT_W  results delivered.
- correct_cnt  out  CNT_W  results where pred equals the zero-extended label.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, LAUNCH, WAIT and HOLD.
REQ-004 IDLE: img_ready SHALL be 1; when img_valid=1, img_in and lbl_in SHALL be latched and the next state SHALL be LAUNCH.
REQ-005 LAUNCH SHALL last exactly one cycle, drive valid_top=1, and go to WAIT.
REQ-006 valid_top SHALL be 0 in every state except LAUNCH.
REQ-007 img_source SHALL hold the latched image, unchanged, from LAUNCH until the state returns to IDLE.
REQ-008 In WAIT, the first cycle with ready_top=1 SHALL capture number into pred, set pred_timeout=0, and go to HOLD.
REQ-009 ready_top SHALL be ignored in IDLE, LAUNCH and HOLD.
REQ-010 In WAIT, ready_top=1 in the same cycle the watchdog expires SHALL count as a normal result; the result takes priority.
REQ-011 In HOLD, pred_valid SHALL be 1 and pred and pred_timeout SHALL stay stable.
REQ-012 In HOLD, when pred_ready=1, the state SHALL return to IDLE.
REQ-013 In the same HOLD cycle with pred_ready=1, frame_cnt SHALL increment by 1.
REQ-014 In the same HOLD cycle with pred_ready=1, correct_cnt SHALL increment by 1 only if pred_timeout=0 and pred equals the zero-extended label.
REQ-015 frame_cnt and correct_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-016 img_ready SHALL be 0 outside IDLE, so only one frame is in flight.
REQ-017 A frame SHALL NOT be accepted in the same cycle that HOLD completes; there is one bubble cycle in IDLE before the next acceptance.
REQ-018 Minimum frame period SHALL be 4 cycles plus network latency: IDLE, LAUNCH, WAIT (latency), HOLD.

Reset
REQ-019 While rst=1, the state SHALL be IDLE.
REQ-020 While rst=1, valid_top, pred_valid, pred_timeout and busy SHALL be 0.
REQ-021 While rst=1, pred, img_source, frame_cnt, correct_cnt and the watchdog counter SHALL be 0.
REQ-022 While rst=1, img_ready SHALL be 0; it SHALL be 1 from the first cycle after rst deasserts.
REQ-023 Reset asserted mid-frame, in any state, SHALL abandon the frame with no result and no counter update.

Configuration
REQ-024 The macro TCB_WATCHDOG_EN SHALL control the watchdog.
REQ-025 With TCB_WATCHDOG_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-026 With TCB_WATCHDOG_EN defined: when the counter reaches TIMEOUT_CYC with ready_top=0, pred SHALL be all-ones, pred_timeout SHALL be 1, and the state SHALL go to HOLD.
REQ-027 Without TCB_WATCHDOG_EN: no watchdog counter SHALL exist, pred_timeout SHALL be tied to 0, and WAIT SHALL wait indefinitely for ready_top.

Structure
REQ-028 A shared package tcb_pkg SHALL hold the FSM state enum (IDLE/LAUNCH/WAIT/HOLD, 2-bit encoding) and the default constants IMG_W, PRED_W, LBL_W and CNT_W.
REQ-029 One sub-module, tcb_sat_cnt, SHALL implement the saturating counter with increment enable and synchronous clear; it SHALL be instanced twice.
REQ-030 No other hierarchy SHALL exist.

Verification
REQ-031 Single frame: img_in=pattern A, lbl_in=3, img_valid=1 one cycle; ready_top=1 five cycles after valid_top with number=3; pred_ready=1 -> valid_top high exactly 1 cycle; pred=3; frame_cnt=1; correct_cnt=1.
REQ-032 Mismatch with backpressure: number=7, lbl_in=2, pred_ready held low 10 cycles -> pred=7 stable throughout; pred_valid=1; img_ready=0; after acceptance frame_cnt+1 and correct_cnt unchanged.
REQ-033 Back-to-back: img_valid held high for 3 frames -> exactly 3 valid_top pulses; img_source changes only in IDLE; frame_cnt=3.
REQ-034 Watchdog (TCB_WATCHDOG_EN, TIMEOUT_CYC=15): ready_top never rises -> after 15 WAIT cycles pred=0xFFFFFFFF and pred_timeout=1; correct_cnt unchanged.
REQ-035 Watchdog tie (TCB_WATCHDOG_EN): ready_top=1 in the expiry cycle -> pred_timeout=0 and pred=number.
REQ-036 Reset in WAIT: rst=1 for 1 cycle in WAIT -> all outputs zero; a late ready_top in IDLE produces no pred_valid; counters stay 0.
